// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multicycle MIPS control FSM (Moore) driving PC/IR/MDR/ALU_Out, register file and CP0.
// Revision 1.0 - initial release
`default_nettype none

module mc_ctrl_unit #(
   parameter int ST_W       = 5,
   parameter bit EXC_ON_OVF = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     Inst_in,
   input  logic            zero,
   input  logic            overflow,
   input  logic            MIO_ready,
   output logic            IorD,
   output logic            IRWrite,
   output logic            RegWrite,
   output logic            ALUSrcA,
   output logic            PCWrite,
   output logic            PCWriteCond,
   output logic            Beq,
   output logic            MemRead,
   output logic            MemWrite,
   output logic [1:0]      RegDst,
   output logic [1:0]      ALUSrcB,
   output logic [2:0]      MemtoReg,
   output logic [2:0]      PCSource,
   output logic [2:0]      ALU_operation,
   output logic            CauseWrite,
   output logic            EPCWrite,
   output logic            Co0Write,
   output logic [1:0]      IntCause,
   output logic [ST_W-1:0] state_o
);

   typedef enum logic [ST_W-1:0] {
      S_IF, S_ID, S_MEM_ADR, S_MEM_RD, S_WB_LW, S_MEM_WR, S_EX_R, S_WB_R, S_EX_I,
      S_WB_I, S_BRANCH, S_JUMP, S_JAL, S_LUI, S_MFC0, S_MTC0, S_ERET, S_EXC
   } state_t;

   localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010, ALU_XOR = 3'b011,
                          ALU_NOR = 3'b100, ALU_SUB = 3'b110, ALU_SLT = 3'b111;

   state_t      state, nxt_state;
   logic [1:0]  cause_r, exc_cause;
   logic [5:0]  op, funct;
   logic [4:0]  rs;
   logic        unused_bits;

   assign op          = Inst_in[31:26];
   assign rs          = Inst_in[25:21];
   assign funct       = Inst_in[5:0];
   // zero is consumed by the data path through PCWriteCond/Beq, not by the FSM
   assign unused_bits = ^{Inst_in[20:6], zero};
   assign state_o     = state;

   function automatic logic [2:0] r_alu(input logic [5:0] f);
      case (f)
         6'b100010, 6'b100011: r_alu = ALU_SUB;
         6'b100100:            r_alu = ALU_AND;
         6'b100101:            r_alu = ALU_OR;
         6'b100110:            r_alu = ALU_XOR;
         6'b100111:            r_alu = ALU_NOR;
         6'b101010:            r_alu = ALU_SLT;
         default:              r_alu = ALU_ADD;
      endcase
   endfunction

   function automatic logic [2:0] i_alu(input logic [5:0] o);
      case (o)
         6'b001010: i_alu = ALU_SLT;
         6'b001100: i_alu = ALU_AND;
         6'b001101: i_alu = ALU_OR;
         6'b001110: i_alu = ALU_XOR;
         default:   i_alu = ALU_ADD;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IF;
         cause_r <= 2'b00;
      end else begin
         state <= nxt_state;
         if (nxt_state == S_EXC) cause_r <= exc_cause;
      end
   end

   always_comb begin
      nxt_state     = S_IF;
      exc_cause     = 2'b00;
      IorD          = 1'b0;
      IRWrite       = 1'b0;
      RegWrite      = 1'b0;
      ALUSrcA       = 1'b0;
      PCWrite       = 1'b0;
      PCWriteCond   = 1'b0;
      Beq           = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      RegDst        = 2'b00;
      ALUSrcB       = 2'b00;
      MemtoReg      = 3'b000;
      PCSource      = 3'b000;
      ALU_operation = ALU_AND;
      CauseWrite    = 1'b0;
      EPCWrite      = 1'b0;
      Co0Write      = 1'b0;
      IntCause      = 2'b00;
      case (state)
         S_IF: begin
            IorD = 1'b1; MemRead = 1'b1; IRWrite = 1'b1; ALUSrcA = 1'b1;
            ALUSrcB = 2'b01; ALU_operation = ALU_ADD; PCWrite = 1'b1;
            nxt_state = MIO_ready ? S_ID : S_IF;
         end
         S_ID: begin
            ALUSrcA = 1'b1; ALUSrcB = 2'b11; ALU_operation = ALU_ADD;
            exc_cause = 2'b10;
            nxt_state = S_EXC;
            case (op)
               6'b000000: begin
                  if (funct inside {6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                    6'b100101, 6'b100110, 6'b100111, 6'b101010})
                     nxt_state = S_EX_R;
                  else if (funct == 6'b001100)
                     exc_cause = 2'b11;
               end
               6'b100011, 6'b101011:             nxt_state = S_MEM_ADR;
               6'b001000, 6'b001001, 6'b001010,
               6'b001100, 6'b001101, 6'b001110:  nxt_state = S_EX_I;
               6'b001111:                        nxt_state = S_LUI;
               6'b000100, 6'b000101:             nxt_state = S_BRANCH;
               6'b000010:                        nxt_state = S_JUMP;
               6'b000011:                        nxt_state = S_JAL;
               6'b010000: begin
                  if (rs == 5'b00000)                             nxt_state = S_MFC0;
                  else if (rs == 5'b00100)                        nxt_state = S_MTC0;
                  else if (rs == 5'b10000 && funct == 6'b011000)  nxt_state = S_ERET;
               end
               default: ;
            endcase
         end
         S_MEM_ADR: begin
            ALUSrcB = 2'b10; ALU_operation = ALU_ADD;
            nxt_state = (op == 6'b100011) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            MemRead   = 1'b1;
            nxt_state = MIO_ready ? S_WB_LW : S_MEM_RD;
         end
         S_WB_LW: begin
            MemtoReg = 3'b001; RegWrite = 1'b1;
         end
         S_MEM_WR: begin
            MemWrite  = 1'b1;
            nxt_state = MIO_ready ? S_IF : S_MEM_WR;
         end
         S_EX_R: begin
            ALU_operation = r_alu(funct);
            // addu/subu never trap; only the signed forms honour overflow
            if (EXC_ON_OVF && overflow && (funct == 6'b100000 || funct == 6'b100010)) begin
               nxt_state = S_EXC; exc_cause = 2'b01;
            end else begin
               nxt_state = S_WB_R;
            end
         end
         S_WB_R: begin
            RegDst = 2'b01; RegWrite = 1'b1;
         end
         S_EX_I: begin
            ALUSrcB = 2'b10; ALU_operation = i_alu(op);
            if (EXC_ON_OVF && overflow && op == 6'b001000) begin
               nxt_state = S_EXC; exc_cause = 2'b01;
            end else begin
               nxt_state = S_WB_I;
            end
         end
         S_WB_I:   RegWrite = 1'b1;
         S_BRANCH: begin
            ALU_operation = ALU_SUB; PCWriteCond = 1'b1; PCSource = 3'b001;
            Beq = (op == 6'b000100);
         end
         S_JUMP: begin
            PCWrite = 1'b1; PCSource = 3'b010;
         end
         S_JAL: begin
            PCWrite = 1'b1; PCSource = 3'b010; RegDst = 2'b10; MemtoReg = 3'b011; RegWrite = 1'b1;
         end
         S_LUI: begin
            MemtoReg = 3'b010; RegWrite = 1'b1;
         end
         S_MFC0: begin
            MemtoReg = 3'b100; RegWrite = 1'b1;
         end
         S_MTC0:   Co0Write = 1'b1;
         S_ERET: begin
            PCWrite = 1'b1; PCSource = 3'b100;
         end
         S_EXC: begin
            // ALU computes PC-4 so EPC points at the faulting instruction
            ALUSrcA = 1'b1; ALUSrcB = 2'b01; ALU_operation = ALU_SUB;
            EPCWrite = 1'b1; CauseWrite = 1'b1; IntCause = cause_r;
            PCWrite = 1'b1; PCSource = 3'b011;
         end
         default: nxt_state = S_IF;
      endcase
   end

endmodule

`default_nettype wire
